// File: rtl/fasttwosum_stream_accum.sv
`default_nettype none
// ============================================================================
// Module      : fasttwosum_stream_accum
// Description : Streaming signed reduction. Each valid beat of LANES operands
//               is summed by a fully registered binary adder tree. A
//               post-tree accumulator then adds successive beats until the
//               last beat, or until MAX_BEATS beats have been taken.
//               Optional feature macro: FTS_ACCUM_SATURATE_EN
//                 defined   -> the accumulator clamps on overflow
//                 undefined -> the accumulator wraps modulo 2**ACC_WIDTH_O
// Revision    : 1.0 - initial release
// ============================================================================
module fasttwosum_stream_accum #(
    parameter int DATA_WIDTH_I = 8,
    parameter int LANES        = 32,
    parameter int MAX_BEATS    = 16,
    parameter int ACC_WIDTH_O  = DATA_WIDTH_I + $clog2(LANES) + $clog2(MAX_BEATS)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              i_valid,
    input  logic                              i_last,
    input  logic [LANES*DATA_WIDTH_I-1:0]     i_vec,
    output logic                              o_valid,
    output logic [ACC_WIDTH_O-1:0]            o_sum,
    output logic [$clog2(MAX_BEATS+1)-1:0]    o_beats,
    output logic                              o_forced,
    output logic                              o_overflow
);

    localparam int TREE_DEPTH = $clog2(LANES);
    localparam int TREE_WIDTH = DATA_WIDTH_I + TREE_DEPTH;
    localparam int PADDED     = 1 << TREE_DEPTH;
    localparam int CNT_W      = $clog2(MAX_BEATS + 1);
    localparam int MAX_W      = (ACC_WIDTH_O > TREE_WIDTH) ? ACC_WIDTH_O : TREE_WIDTH;
    localparam int SUM_W      = MAX_W + 1;

    // Input lanes, zero-padded up to a power of two so every tree level pairs evenly
    logic [DATA_WIDTH_I-1:0] lane_in [PADDED];

    for (genvar j = 0; j < PADDED; j++) begin : g_pad
        if (j < LANES) begin : g_lane
            assign lane_in[j] = i_vec[j*DATA_WIDTH_I +: DATA_WIDTH_I];
        end else begin : g_zero
            assign lane_in[j] = '0;
        end
    end

    // Level 0 is the input register; level k holds PADDED>>k partial sums,
    // each one bit wider than the level before so no tree add can overflow.
    for (genvar k = 0; k <= TREE_DEPTH; k++) begin : g_lvl
        localparam int NODES = PADDED >> k;
        localparam int LW    = DATA_WIDTH_I + k;

        logic [LW-1:0] node [NODES];
        logic          vld;
        logic          lst;

        if (k == 0) begin : g_stage0
            // Capture the beat; a last flag without valid is dropped here
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    vld <= 1'b0;
                    lst <= 1'b0;
                    for (int j = 0; j < NODES; j++) node[j] <= '0;
                end else begin
                    vld <= i_valid;
                    lst <= i_valid & i_last;
                    for (int j = 0; j < NODES; j++) node[j] <= lane_in[j];
                end
            end
        end else begin : g_add
            // Sign-extended pairwise add, with valid/last travelling alongside
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    vld <= 1'b0;
                    lst <= 1'b0;
                    for (int j = 0; j < NODES; j++) node[j] <= '0;
                end else begin
                    vld <= g_lvl[k-1].vld;
                    lst <= g_lvl[k-1].lst;
                    for (int j = 0; j < NODES; j++) begin
                        node[j] <= {g_lvl[k-1].node[2*j][LW-2],   g_lvl[k-1].node[2*j]}
                                 + {g_lvl[k-1].node[2*j+1][LW-2], g_lvl[k-1].node[2*j+1]};
                    end
                end
            end
        end
    end

    logic [TREE_WIDTH-1:0] tree_sum;
    logic                  tree_vld;
    logic                  tree_lst;

    assign tree_sum = g_lvl[TREE_DEPTH].node[0];
    assign tree_vld = g_lvl[TREE_DEPTH].vld;
    assign tree_lst = g_lvl[TREE_DEPTH].lst;

    // Accumulator state
    logic [ACC_WIDTH_O-1:0]   acc;
    logic [CNT_W-1:0]         cnt;
    logic                     acc_ovf;

    // Terminated vector, staged one cycle before the output register
    logic                     done;
    logic [ACC_WIDTH_O-1:0]   fin_sum;
    logic [CNT_W-1:0]         fin_beats;
    logic                     fin_forced;
    logic                     fin_ovf;

    logic [SUM_W-1:0]             sum_ext;
    logic [SUM_W-ACC_WIDTH_O:0]   sum_hi;
    logic                         sum_ovf;
    logic [ACC_WIDTH_O-1:0]       acc_next;
    logic [CNT_W-1:0]             cnt_next;
    logic                         max_hit;
    logic                         term;

    // Exact sum at a width that cannot overflow, then range check and reduce.
    // The sum fits ACC_WIDTH_O iff all bits from the result sign bit upward agree.
    always_comb begin
        sum_ext  = {{(SUM_W-ACC_WIDTH_O){acc[ACC_WIDTH_O-1]}}, acc}
                 + {{(SUM_W-TREE_WIDTH){tree_sum[TREE_WIDTH-1]}}, tree_sum};
        sum_hi   = sum_ext[SUM_W-1:ACC_WIDTH_O-1];
        sum_ovf  = ~((&sum_hi) | ~(|sum_hi));
`ifdef FTS_ACCUM_SATURATE_EN
        if (sum_ovf) begin
            acc_next = sum_ext[SUM_W-1] ? {1'b1, {(ACC_WIDTH_O-1){1'b0}}}
                                        : {1'b0, {(ACC_WIDTH_O-1){1'b1}}};
        end else begin
            acc_next = sum_ext[ACC_WIDTH_O-1:0];
        end
`else
        acc_next = sum_ext[ACC_WIDTH_O-1:0];
`endif
        cnt_next = cnt + CNT_W'(1);
        max_hit  = (cnt_next == CNT_W'(MAX_BEATS));
        term     = tree_vld & (tree_lst | max_hit);
    end

    // Accumulate tree results; on termination hand off and start a fresh vector
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc        <= '0;
            cnt        <= '0;
            acc_ovf    <= 1'b0;
            done       <= 1'b0;
            fin_sum    <= '0;
            fin_beats  <= '0;
            fin_forced <= 1'b0;
            fin_ovf    <= 1'b0;
        end else begin
            done <= term;
            if (tree_vld) begin
                if (term) begin
                    acc        <= '0;
                    cnt        <= '0;
                    acc_ovf    <= 1'b0;
                    fin_sum    <= acc_next;
                    fin_beats  <= cnt_next;
                    fin_forced <= max_hit & ~tree_lst;
                    fin_ovf    <= acc_ovf | sum_ovf;
                end else begin
                    acc        <= acc_next;
                    cnt        <= cnt_next;
                    acc_ovf    <= acc_ovf | sum_ovf;
                end
            end
        end
    end

    // Result register: loads only on a strobe, otherwise holds the last vector
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            o_valid    <= 1'b0;
            o_sum      <= '0;
            o_beats    <= '0;
            o_forced   <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_valid <= done;
            if (done) begin
                o_sum      <= fin_sum;
                o_beats    <= fin_beats;
                o_forced   <= fin_forced;
                o_overflow <= fin_ovf;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fasttwosum_stream_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_fasttwosum_stream_accum
// Description : Self-checking bench. Three instances: defaults (A),
//               MAX_BEATS=4 / ACC_WIDTH_O=12 (B), LANES=5 (C). Expected
//               results are queued when the terminating beat is driven and
//               compared, including arrival cycle, when o_valid strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fasttwosum_stream_accum;

    typedef struct {
        longint sum;
        int     beats;
        bit     forced;
        bit     ovf;
        int     cyc;
    } exp_t;

    typedef struct {
        int     val;
        int     nbeats;
        bit     gap;
        longint sum;
        int     beats;
    } vec_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    // Instance A: defaults
    logic         a_valid, a_last;
    logic [255:0] a_vec;
    logic         a_oval, a_forced, a_ovf;
    logic [16:0]  a_sum;
    logic [4:0]   a_beats;

    // Instance B: MAX_BEATS=4, ACC_WIDTH_O=12
    logic         b_valid, b_last;
    logic [255:0] b_vec;
    logic         b_oval, b_forced, b_ovf;
    logic [11:0]  b_sum;
    logic [2:0]   b_beats;

    // Instance C: LANES=5
    logic         c_valid, c_last;
    logic [39:0]  c_vec;
    logic         c_oval, c_forced, c_ovf;
    logic [14:0]  c_sum;
    logic [4:0]   c_beats;

    fasttwosum_stream_accum u_a (
        .clk_i(clk), .rst_ni(rst_n), .i_valid(a_valid), .i_last(a_last), .i_vec(a_vec),
        .o_valid(a_oval), .o_sum(a_sum), .o_beats(a_beats), .o_forced(a_forced), .o_overflow(a_ovf)
    );

    fasttwosum_stream_accum #(.MAX_BEATS(4), .ACC_WIDTH_O(12)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .i_valid(b_valid), .i_last(b_last), .i_vec(b_vec),
        .o_valid(b_oval), .o_sum(b_sum), .o_beats(b_beats), .o_forced(b_forced), .o_overflow(b_ovf)
    );

    fasttwosum_stream_accum #(.LANES(5)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .i_valid(c_valid), .i_last(c_last), .i_vec(c_vec),
        .o_valid(c_oval), .o_sum(c_sum), .o_beats(c_beats), .o_forced(c_forced), .o_overflow(c_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input longint s, input int b, input bit f, input bit o, input int lat);
        exp_t e;
        e.sum = s; e.beats = b; e.forced = f; e.ovf = o; e.cyc = cyc + lat + 1;
        return e;
    endfunction

    // Scoreboard monitors, sampled on the falling edge
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (a_oval) begin
            if (qa.size() == 0) chk("a_unexpected_strobe", 1, 0);
            else begin
                e = qa.pop_front();
                chk("a_sum", $signed(a_sum), e.sum);
                chk("a_beats", a_beats, e.beats);
                chk("a_forced", a_forced, e.forced);
                chk("a_overflow", a_ovf, e.ovf);
                chk("a_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (b_oval) begin
            if (qb.size() == 0) chk("b_unexpected_strobe", 1, 0);
            else begin
                e = qb.pop_front();
                chk("b_sum", $signed(b_sum), e.sum);
                chk("b_beats", b_beats, e.beats);
                chk("b_forced", b_forced, e.forced);
                chk("b_overflow", b_ovf, e.ovf);
                chk("b_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (c_oval) begin
            if (qc.size() == 0) chk("c_unexpected_strobe", 1, 0);
            else begin
                e = qc.pop_front();
                chk("c_sum", $signed(c_sum), e.sum);
                chk("c_beats", c_beats, e.beats);
                chk("c_forced", c_forced, e.forced);
                chk("c_overflow", c_ovf, e.ovf);
                chk("c_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic beat_a(input bit v, input bit l, input int val);
        a_valid = v; a_last = l;
        for (int j = 0; j < 32; j++) a_vec[j*8 +: 8] = val[7:0];
        @(negedge clk);
    endtask

    task automatic beat_b(input bit v, input bit l, input int val);
        b_valid = v; b_last = l;
        for (int j = 0; j < 32; j++) b_vec[j*8 +: 8] = val[7:0];
        @(negedge clk);
    endtask

    task automatic beat_c(input bit v, input bit l, input int x0, input int x1,
                          input int x2, input int x3, input int x4);
        c_valid = v; c_last = l;
        c_vec = {x4[7:0], x3[7:0], x2[7:0], x1[7:0], x0[7:0]};
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t tbl[6];
        int   n;

        tbl[0] = '{val: 1,    nbeats: 1,  gap: 1'b0, sum: 32,     beats: 1};
        tbl[1] = '{val: -1,   nbeats: 3,  gap: 1'b1, sum: -96,    beats: 3};
        tbl[2] = '{val: 2,    nbeats: 1,  gap: 1'b0, sum: 64,     beats: 1};
        tbl[3] = '{val: -128, nbeats: 1,  gap: 1'b0, sum: -4096,  beats: 1};
        tbl[4] = '{val: 127,  nbeats: 16, gap: 1'b0, sum: 65024,  beats: 16};
        tbl[5] = '{val: -128, nbeats: 16, gap: 1'b0, sum: -65536, beats: 16};

        cyc = 0; checks = 0; failures = 0;
        rst_n = 1'b0;
        a_valid = 0; a_last = 0; a_vec = '0;
        b_valid = 0; b_last = 0; b_vec = '0;
        c_valid = 0; c_last = 0; c_vec = '0;
        repeat (3) @(negedge clk);

        chk("reset_o_valid", a_oval, 0);
        chk("reset_o_sum", a_sum, 0);
        chk("reset_o_beats", a_beats, 0);
        chk("reset_o_forced", a_forced, 0);
        chk("reset_o_overflow", a_ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // A: table of vectors, driven back-to-back; the gap beat carries
        // i_last without i_valid, which must be ignored
        foreach (tbl[i]) begin
            for (int b = 0; b < tbl[i].nbeats; b++) begin
                if (b == tbl[i].nbeats - 1) qa.push_back(mk(tbl[i].sum, tbl[i].beats, 1'b0, 1'b0, 7));
                beat_a(1'b1, b == tbl[i].nbeats - 1, tbl[i].val);
                if (tbl[i].gap && b == 0) beat_a(1'b0, 1'b1, tbl[i].val);
            end
        end
        a_valid = 0; a_last = 0;
        repeat (12) @(negedge clk);
        chk("a_hold_sum", $signed(a_sum), -65536);
        chk("a_hold_valid", a_oval, 0);

        // B: forced termination, then the trailing last closes a 2-beat vector
        for (int b = 0; b < 6; b++) begin
            if (b == 3) qb.push_back(mk(128, 4, 1'b1, 1'b0, 7));
            if (b == 5) qb.push_back(mk(64, 2, 1'b0, 1'b0, 7));
            beat_b(1'b1, b == 5, 1);
        end
        // B: last coincides with the MAX_BEATS hit -> normal termination
        for (int b = 0; b < 4; b++) begin
            if (b == 3) qb.push_back(mk(128, 4, 1'b0, 1'b0, 7));
            beat_b(1'b1, b == 3, 1);
        end
        // B: overflow of the 12-bit accumulator
        beat_b(1'b1, 1'b0, 127);
`ifdef FTS_ACCUM_SATURATE_EN
        qb.push_back(mk(2047, 2, 1'b0, 1'b1, 7));
`else
        qb.push_back(mk(-64, 2, 1'b0, 1'b1, 7));
`endif
        beat_b(1'b1, 1'b1, 127);
        // B: sticky overflow must not leak into the next vector
        qb.push_back(mk(32, 1, 1'b0, 1'b0, 7));
        beat_b(1'b1, 1'b1, 1);
        b_valid = 0; b_last = 0;

        // C: non-power-of-two lane count
        qc.push_back(mk(15, 1, 1'b0, 1'b0, 5));
        beat_c(1'b1, 1'b1, 1, 2, 3, 4, 5);
        beat_c(1'b1, 1'b0, -128, -128, -128, -128, -128);
        beat_c(1'b0, 1'b0, 0, 0, 0, 0, 0);
        qc.push_back(mk(-1280, 2, 1'b0, 1'b0, 5));
        beat_c(1'b1, 1'b1, -128, -128, -128, -128, -128);
        c_valid = 0; c_last = 0;
        repeat (12) @(negedge clk);

        // A: reset mid-vector discards the partial vector and in-flight beats
        beat_a(1'b1, 1'b0, 1);
        beat_a(1'b1, 1'b0, 1);
        a_valid = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("rst_o_valid", a_oval, 0);
        chk("rst_o_sum", a_sum, 0);
        chk("rst_o_beats", a_beats, 0);
        chk("rst_o_forced", a_forced, 0);
        chk("rst_o_overflow", a_ovf, 0);
        qa.push_back(mk(96, 1, 1'b0, 1'b0, 7));
        beat_a(1'b1, 1'b1, 3);
        a_valid = 0; a_last = 0;

        // Drain with a bounded wait
        n = 0;
        while ((qa.size() + qb.size() + qc.size()) != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", qa.size() + qb.size() + qc.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
